// File: rtl/cp0_exception_unit_pkg.sv
// Shared CP0 definitions: exception codes, register numbers, SR/Cause field
// positions and the exception entry address used by the PC mux.
package cp0_exception_unit_pkg;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
  localparam logic [31:0] PRID_VALUE   = 32'h2024_0829;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;
  localparam logic [4:0] EXC_NONE    = 5'd0;

  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  localparam int unsigned SR_IM_HI     = 15;
  localparam int unsigned SR_IM_LO     = 10;
  localparam int unsigned SR_EXL       = 1;
  localparam int unsigned SR_IE        = 0;
  localparam int unsigned CAUSE_BD     = 31;
  localparam int unsigned CAUSE_IP_HI  = 15;
  localparam int unsigned CAUSE_IP_LO  = 10;
  localparam int unsigned CAUSE_EXC_HI = 6;
  localparam int unsigned CAUSE_EXC_LO = 2;

  function automatic logic [31:0] pack_sr(input logic [5:0] im,
                                          input logic       exl,
                                          input logic       ie);
    logic [31:0] v;
    v                     = 32'h0000_0000;
    v[SR_IM_HI:SR_IM_LO]  = im;
    v[SR_EXL]             = exl;
    v[SR_IE]              = ie;
    return v;
  endfunction

  function automatic logic [31:0] pack_cause(input logic       bd,
                                             input logic [5:0] ip,
                                             input logic [4:0] exc);
    logic [31:0] v;
    v                           = 32'h0000_0000;
    v[CAUSE_BD]                 = bd;
    v[CAUSE_IP_HI:CAUSE_IP_LO]  = ip;
    v[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc;
    return v;
  endfunction

endpackage

// File: rtl/cp0_exception_unit.sv
// Memory-stage CP0: decides exception/interrupt entry, records SR/Cause/EPC,
// and serves mfc0/mtc0/eret. Only the implemented SR/Cause fields are stored.
module cp0_exception_unit
  import cp0_exception_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] DOut,
  output logic [31:0] EPCOut,
  output logic        Req
);

  logic [5:0]  r_sr_im;
  logic        r_sr_exl;
  logic        r_sr_ie;
  logic        r_cause_bd;
  logic [5:0]  r_cause_ip;
  logic [4:0]  r_cause_exc;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic [31:0] w_dout;

  // Exception/interrupt decision; EXL blocks nesting of both kinds
  always_comb begin
    w_int_req = (|(HWInt & r_sr_im)) & r_sr_ie & ~r_sr_exl;
    w_exc_req = (ExcCodeIn != EXC_NONE) & ~r_sr_exl;
    w_req     = w_int_req | w_exc_req;
  end

  // mfc0 read mux over current register contents (no bypass of same-cycle writes)
  always_comb begin
    w_dout  = 32'h0000_0000;
    w_sr    = pack_sr(r_sr_im, r_sr_exl, r_sr_ie);
    w_cause = pack_cause(r_cause_bd, r_cause_ip, r_cause_exc);
    case (A1)
      CP0_SR:    w_dout = w_sr;
      CP0_CAUSE: w_dout = w_cause;
      CP0_EPC:   w_dout = r_epc;
      CP0_PRID:  w_dout = PRID_VALUE;
      default:   w_dout = 32'h0000_0000;
    endcase
  end

  assign Req    = w_req;
  assign DOut   = w_dout;
  assign EPCOut = r_epc;

  // Pending-interrupt mirror follows the lines every cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cause_ip <= 6'd0;
    end else begin
      r_cause_ip <= HWInt;
    end
  end

  // Exception entry beats eret, which beats mtc0; a write on an entry edge is dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr_im     <= 6'd0;
      r_sr_exl    <= 1'b0;
      r_sr_ie     <= 1'b0;
      r_cause_bd  <= 1'b0;
      r_cause_exc <= 5'd0;
      r_epc       <= 32'h0000_0000;
    end else if (w_req) begin
      r_sr_exl    <= 1'b1;
      r_cause_bd  <= BDIn;
      r_cause_exc <= w_int_req ? EXC_INT : ExcCodeIn;
      r_epc       <= BDIn ? (VPC - 32'd4) : VPC;
    end else begin
      if (WE && (A2 == CP0_SR)) begin
        r_sr_im  <= DIn[SR_IM_HI:SR_IM_LO];
        r_sr_ie  <= DIn[SR_IE];
        r_sr_exl <= EXLClr ? 1'b0 : DIn[SR_EXL];
      end else if (EXLClr) begin
        r_sr_exl <= 1'b0;
      end
      if (WE && (A2 == CP0_EPC)) begin
        r_epc <= DIn;
      end
    end
  end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Scoreboard bench: directed scenarios plus random traffic, checked against a
// word-level CP0 model; a negedge monitor compares Req, DOut and EPCOut.
module tb_cp0_exception_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  A1 = 5'd0;
  logic [4:0]  A2 = 5'd0;
  logic [31:0] DIn = 32'd0;
  logic        WE = 1'b0;
  logic [31:0] VPC = 32'd0;
  logic        BDIn = 1'b0;
  logic [4:0]  ExcCodeIn = 5'd0;
  logic [5:0]  HWInt = 6'd0;
  logic        EXLClr = 1'b0;
  logic [31:0] DOut;
  logic [31:0] EPCOut;
  logic        Req;

  int checks = 0;
  int failures = 0;
  int cyc_id = 0;

  typedef struct {
    int          id;
    logic        req;
    logic [31:0] dout;
    logic [31:0] epc;
  } exp_t;
  exp_t sb_q[$];

  // Model state as architectural 32-bit words
  logic [31:0] m_sr = 32'd0;
  logic [31:0] m_cause = 32'd0;
  logic [31:0] m_epc = 32'd0;

  cp0_exception_unit dut (
    .clk(clk), .reset_n(reset_n), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
    .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
    .EXLClr(EXLClr), .DOut(DOut), .EPCOut(EPCOut), .Req(Req)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_read(input logic [4:0] n);
    case (n)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h2024_0829;
      default: return 32'd0;
    endcase
  endfunction

  task automatic cyc(input logic [4:0] a1, input logic [4:0] a2,
                     input logic [31:0] din, input logic we,
                     input logic [31:0] vpc, input logic bd,
                     input logic [4:0] code, input logic [5:0] hw,
                     input logic clr, input bit rst_mid, input bit rst_hold);
    exp_t e;
    logic exl, ie, int_req, exc_req, req;
    logic [5:0] im;
    @(posedge clk);
    #1;
    reset_n = rst_hold ? 1'b0 : 1'b1;
    A1 = a1; A2 = a2; DIn = din; WE = we; VPC = vpc; BDIn = bd;
    ExcCodeIn = code; HWInt = hw; EXLClr = clr;
    if (rst_mid) begin
      #1;
      reset_n = 1'b0;
    end
    if (rst_mid || rst_hold) begin
      m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
    end
    im  = m_sr[15:10];
    exl = m_sr[1];
    ie  = m_sr[0];
    int_req = ((hw & im) != 6'd0) && ie && !exl;
    exc_req = (code != 5'd0) && !exl;
    req = int_req || exc_req;
    e.id = cyc_id; e.req = req; e.dout = m_read(a1); e.epc = m_epc;
    sb_q.push_back(e);
    cyc_id++;
    if (!(rst_mid || rst_hold)) begin
      m_cause = (m_cause & ~32'h0000_FC00) | {16'd0, hw, 10'd0};
      if (req) begin
        m_sr = m_sr | 32'h0000_0002;
        m_cause = {bd, m_cause[30:7], (int_req ? 5'd0 : code), m_cause[1:0]};
        m_epc = bd ? vpc - 32'd4 : vpc;
      end else begin
        if (we && a2 == 5'd12) m_sr = din & 32'h0000_FC03;
        if (clr) m_sr = m_sr & ~32'h0000_0002;
        if (we && a2 == 5'd14) m_epc = din;
      end
    end
  endtask

  task automatic idle(input logic [4:0] a1);
    cyc(a1, 5'd0, 32'd0, 1'b0, 32'h0000_3000, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare every presented cycle against the queued expectation
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks += 3;
      if (Req !== e.req) begin
        failures++;
        $display("FAIL req cyc=%0d got=%0b exp=%0b", e.id, Req, e.req);
      end
      if (DOut !== e.dout) begin
        failures++;
        $display("FAIL dout cyc=%0d A1=%0d got=%h exp=%h", e.id, A1, DOut, e.dout);
      end
      if (EPCOut !== e.epc) begin
        failures++;
        $display("FAIL epcout cyc=%0d got=%h exp=%h", e.id, EPCOut, e.epc);
      end
    end
  end

  initial begin
    logic [4:0] codes [5];
    logic [4:0] a1, a2, code;
    logic [5:0] hw;
    int n;
    codes[0] = 5'd0; codes[1] = 5'd4; codes[2] = 5'd5; codes[3] = 5'd10; codes[4] = 5'd12;

    // Reset state
    cyc(5'd15, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b1);
    cyc(5'd14, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b1);
    // Fetch AdEL, misaligned PC preserved
    cyc(5'd14, 5'd0, 32'd0, 1'b0, 32'h0000_3001, 1'b0, 5'd4, 6'd0, 1'b0, 1'b0, 1'b0);
    idle(5'd14); idle(5'd13); idle(5'd12);
    cyc(5'd12, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b0, 1'b0);
    idle(5'd12);
    // Delay-slot overflow
    cyc(5'd13, 5'd0, 32'd0, 1'b0, 32'h0000_3008, 1'b1, 5'd12, 6'd0, 1'b0, 1'b0, 1'b0);
    idle(5'd14); idle(5'd13);
    // SR = IM0|IE, then masked and unmasked interrupts
    cyc(5'd12, 5'd12, 32'h0000_0401, 1'b1, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    idle(5'd12);
    cyc(5'd13, 5'd0, 32'd0, 1'b0, 32'h0000_300C, 1'b0, 5'd0, 6'b000010, 1'b0, 1'b0, 1'b0);
    cyc(5'd13, 5'd0, 32'd0, 1'b0, 32'h0000_300C, 1'b0, 5'd0, 6'b000001, 1'b0, 1'b0, 1'b0);
    idle(5'd13);
    cyc(5'd12, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b0, 1'b0);
    // Interrupt and RI together: interrupt wins
    cyc(5'd13, 5'd0, 32'd0, 1'b0, 32'h0000_3010, 1'b0, 5'd10, 6'b000001, 1'b0, 1'b0, 1'b0);
    idle(5'd13);
    // EXL=1 blocks AdES
    cyc(5'd14, 5'd0, 32'd0, 1'b0, 32'h0000_3020, 1'b0, 5'd5, 6'b000001, 1'b0, 1'b0, 1'b0);
    idle(5'd13); idle(5'd14);
    cyc(5'd12, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b0, 1'b0);
    idle(5'd12);
    // mtc0 EPC with concurrent read, then Cause write ignored
    cyc(5'd14, 5'd14, 32'h0000_3100, 1'b1, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    idle(5'd14);
    cyc(5'd13, 5'd13, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    idle(5'd13);
    // Write on an exception edge is dropped
    cyc(5'd14, 5'd14, 32'hDEAD_BEEF, 1'b1, 32'h0000_3040, 1'b0, 5'd4, 6'd0, 1'b0, 1'b0, 1'b0);
    idle(5'd14);
    // Async reset mid-cycle while EXL=1, then wrap of VPC-4
    cyc(5'd12, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    cyc(5'd14, 5'd0, 32'd0, 1'b0, 32'h0000_0000, 1'b1, 5'd12, 6'd0, 1'b0, 1'b0, 1'b0);
    idle(5'd14); idle(5'd13);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(12, 15));
      a2 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(12, 15));
      code = ($urandom_range(0, 2) == 0) ? codes[$urandom_range(0, 4)] : 5'd0;
      hw = ($urandom_range(0, 1) == 1) ? 6'($urandom) : 6'd0;
      cyc(a1, a2, $urandom, 1'($urandom_range(0, 2) == 0), $urandom, 1'($urandom_range(0, 1)),
          code, hw, 1'($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0), 1'b0);
    end

    n = 0;
    while (sb_q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d exp=0", sb_q.size());
    end
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
